riscv_halt_monitor: RTL and testbench

Synthesizable end-of-test monitor for the RISC-V pipeline. It watches the core's data-memory store port for a write to the `tohost` mailbox and runs a cycle-budget watchdog. It reports pass, fail or timeout back to the surrounding bench or SoC, so a run ends on the core's own verdict instead of a fixed cycle count. It sits beside `riscv_pipeline_top` on the data-memory write bus and has no effect on the core.

---
 rtl/riscv_sim_pkg.sv | 33 +++
 rtl/riscv_sat_counter.sv | 24 ++
 rtl/riscv_halt_monitor.sv | 122 ++++++++++++
 tb/tb_riscv_halt_monitor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_sim_pkg.sv
// Shared types and constants for the RISC-V simulation support blocks
// (end-of-test mailbox monitor and its helpers).
package riscv_sim_pkg;

  // Monitor lifecycle: armed by enable, ends in one of three sticky verdicts.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } halt_state_e;

  // Default byte address of the tohost mailbox word.
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  // Mailbox value that signals a passing test.
  localparam logic [31:0] TOHOST_PASS = 32'h0000_0001;

  // Default watchdog budget in RUN cycles (0 disables the watchdog).
  localparam int unsigned CYCLE_LIMIT_DEFAULT = 64;

  // A full-word store to the mailbox address; partial stores never count.
  function automatic logic mailbox_hit(
    input logic        wr_en,
    input logic [31:0] addr,
    input logic [3:0]  be,
    input logic [31:0] tohost
  );
    return wr_en && (addr == tohost) && (be == 4'hF);
  endfunction

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter: clears on clr, counts inc pulses while en is high,
// and sticks at all-ones instead of wrapping.
module riscv_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  // Count register: clear has priority, then a saturating increment.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && inc && (count != MAX_COUNT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/riscv_halt_monitor.sv
// End-of-test monitor: watches the data-memory store bus for a verdict
// written to the tohost mailbox and runs a cycle-budget watchdog. It only
// observes the bus; it never stalls or otherwise affects the core.
//
// Bus semantics: the store port has no handshake. Every cycle with
// dmem_wr_en high is one accepted store (a valid with an implied ready of 1);
// the monitor samples it on that clock edge and never pushes back.
module riscv_halt_monitor
  import riscv_sim_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int unsigned CYCLE_LIMIT = CYCLE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        dmem_wr_en,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_be,
  input  logic [31:0] dmem_wdata,
  input  logic        instr_retire,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count,
  output halt_state_e dbg_state
);

  // Last RUN cycle before the watchdog fires; only meaningful when the
  // watchdog is enabled.
  localparam logic [31:0] LIMIT_LAST = 32'(CYCLE_LIMIT) - 32'd1;
  localparam logic        WDOG_ON    = (CYCLE_LIMIT != 0);

  halt_state_e state_q, state_d;
  logic [30:0] fail_code_q, fail_code_d;

  logic in_run;
  logic valid_wr;
  logic pass_wr;
  logic fail_wr;
  logic limit_hit;

  assign in_run   = (state_q == RUN);
  assign valid_wr = mailbox_hit(dmem_wr_en, dmem_addr, dmem_be, TOHOST_ADDR);

  // Bit 0 set marks a verdict; bit 0 clear is console traffic and is ignored.
  assign pass_wr   = valid_wr && (dmem_wdata == TOHOST_PASS);
  assign fail_wr   = valid_wr && dmem_wdata[0] && (dmem_wdata != TOHOST_PASS);
  assign limit_hit = WDOG_ON && (cycle_count == LIMIT_LAST);

  // Next-state and fail-code decode; a verdict write beats the watchdog.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pass_wr) begin
          state_d = PASS;
        end else if (fail_wr) begin
          state_d     = FAIL;
          fail_code_d = dmem_wdata[31:1];
        end else if (limit_hit) begin
          state_d = TIMEOUT;
        end
      end
      default: begin
        // PASS, FAIL and TIMEOUT hold until reset.
        state_d = state_q;
      end
    endcase
  end

  // State and fail-code registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Cycle counter: one tick per RUN cycle, including the transition cycle.
  riscv_sat_counter #(
    .WIDTH (32)
  ) u_cycle_cnt (
    .clk   (clk),
    .clr   (~reset_n),
    .en    (in_run),
    .inc   (1'b1),
    .count (cycle_count)
  );

  // Retire counter: one tick per retired instruction seen in RUN.
  riscv_sat_counter #(
    .WIDTH (32)
  ) u_retire_cnt (
    .clk   (clk),
    .clr   (~reset_n),
    .en    (in_run),
    .inc   (instr_retire),
    .count (retire_count)
  );

  // Verdict flags decode straight from the state register.
  assign pass      = (state_q == PASS);
  assign fail      = (state_q == FAIL);
  assign timeout   = (state_q == TIMEOUT);
  assign done      = pass || fail || timeout;
  assign fail_code = fail_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_halt_monitor.sv
// Directed bench for riscv_halt_monitor. Two instances share all inputs:
// one with a 64-cycle watchdog and one with the watchdog disabled.
module tb_riscv_halt_monitor;
  import riscv_sim_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        enable;
  logic        dmem_wr_en;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        instr_retire;

  logic        done, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, retire_count;
  halt_state_e dbg_state;

  logic        n_done, n_pass, n_fail, n_timeout;
  logic [30:0] n_fail_code;
  logic [31:0] n_cycle_count, n_retire_count;
  halt_state_e n_dbg_state;

  riscv_halt_monitor #(
    .TOHOST_ADDR (32'h0000_1000),
    .CYCLE_LIMIT (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .instr_retire (instr_retire),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .dbg_state    (dbg_state)
  );

  riscv_halt_monitor #(
    .TOHOST_ADDR (32'h0000_1000),
    .CYCLE_LIMIT (0)
  ) dut_nolimit (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .instr_retire (instr_retire),
    .done         (n_done),
    .pass         (n_pass),
    .fail         (n_fail),
    .timeout      (n_timeout),
    .fail_code    (n_fail_code),
    .cycle_count  (n_cycle_count),
    .retire_count (n_retire_count),
    .dbg_state    (n_dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Packed expectation: {done,pass,fail,timeout, fail_code, cycle, retire}.
  localparam int W = 99;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int errors = 0;
  int checks = 0;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_PASS = 4'b1100;
  localparam logic [3:0] F_FAIL = 4'b1010;
  localparam logic [3:0] F_TOUT = 4'b1001;

  task automatic push_exp(input string tag, input logic [3:0] flags,
                          input logic [30:0] code, input logic [31:0] cyc,
                          input logic [31:0] ret);
    exp_q.push_back({flags, code, cyc, ret});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [W-1:0] e;
    string        t;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert ({done, pass, fail, timeout} === e[98:95]) else begin
      errors++;
      $error("FAIL %s.flags observed=%b expected=%b", t,
             {done, pass, fail, timeout}, e[98:95]);
    end
    checks++;
    assert (fail_code === e[94:64]) else begin
      errors++;
      $error("FAIL %s.fail_code observed=%h expected=%h", t, fail_code, e[94:64]);
    end
    checks++;
    assert (cycle_count === e[63:32]) else begin
      errors++;
      $error("FAIL %s.cycle_count observed=%0d expected=%0d", t, cycle_count, e[63:32]);
    end
    checks++;
    assert (retire_count === e[31:0]) else begin
      errors++;
      $error("FAIL %s.retire_count observed=%0d expected=%0d", t, retire_count, e[31:0]);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    enable       = 1'b0;
    dmem_wr_en   = 1'b0;
    dmem_addr    = 32'h0;
    dmem_be      = 4'h0;
    dmem_wdata   = 32'h0;
    instr_retire = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic arm();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data);
    dmem_wr_en = 1'b1;
    dmem_addr  = addr;
    dmem_be    = be;
    dmem_wdata = data;
    tick();
    dmem_wr_en = 1'b0;
    dmem_addr  = 32'h0;
    dmem_be    = 4'h0;
    dmem_wdata = 32'h0;
  endtask

  // ---------------- watchdog on the bench itself ----------------
  initial begin
    #200000;
    $display("FAIL bench_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle_bus();
    reset_n = 1'b0;
    tick();
    tick();

    // Reset state.
    push_exp("reset", F_NONE, 31'd0, 32'd0, 32'd0);
    do_reset();
    check_out();
    check_val("reset.state", 32'(dbg_state), 32'(IDLE));

    // Pass at RUN cycle 10, then sticky for 20 cycles.
    arm();
    run_cycles(10);
    push_exp("run10", F_NONE, 31'd0, 32'd10, 32'd0);
    check_out();
    push_exp("pass", F_PASS, 31'd0, 32'd11, 32'd0);
    store(32'h1000, 4'hF, 32'h1);
    check_out();
    push_exp("pass_sticky", F_PASS, 31'd0, 32'd11, 32'd0);
    run_cycles(20);
    check_out();

    // Ignored writes: in IDLE, partial BE, console value, wrong address.
    do_reset();
    push_exp("idle_write", F_NONE, 31'd0, 32'd0, 32'd0);
    store(32'h1000, 4'hF, 32'h1);
    check_out();
    check_val("idle_write.state", 32'(dbg_state), 32'(IDLE));
    arm();
    store(32'h1000, 4'h1, 32'h1);
    store(32'h1000, 4'hF, 32'h2);
    push_exp("ignored", F_NONE, 31'd0, 32'd3, 32'd0);
    store(32'h1004, 4'hF, 32'h1);
    check_out();
    check_val("ignored.state", 32'(dbg_state), 32'(RUN));

    // Fail with code 3, later pass write does not override.
    push_exp("fail7", F_FAIL, 31'd3, 32'd4, 32'd0);
    store(32'h1000, 4'hF, 32'h7);
    check_out();
    push_exp("fail_sticky", F_FAIL, 31'd3, 32'd4, 32'd0);
    store(32'h1000, 4'hF, 32'h1);
    check_out();

    // Timeout with limit 64; the unlimited instance keeps running.
    do_reset();
    arm();
    push_exp("pre_timeout", F_NONE, 31'd0, 32'd63, 32'd0);
    run_cycles(63);
    check_out();
    push_exp("timeout", F_TOUT, 31'd0, 32'd64, 32'd0);
    tick();
    check_out();
    check_val("nolimit64.done", 32'(n_done), 32'd0);
    push_exp("timeout_sticky", F_TOUT, 31'd0, 32'd64, 32'd0);
    run_cycles(136);
    check_out();
    check_val("nolimit200.done", 32'(n_done), 32'd0);
    check_val("nolimit200.cycles", n_cycle_count, 32'd200);
    check_val("nolimit200.timeout", 32'(n_timeout), 32'd0);

    // Pass in the limit cycle beats timeout; 40 retires counted.
    do_reset();
    arm();
    for (int i = 0; i < 63; i++) begin
      instr_retire = (i < 40);
      tick();
    end
    instr_retire = 1'b0;
    push_exp("limit_cycle", F_NONE, 31'd0, 32'd63, 32'd40);
    check_out();
    push_exp("limit_pass", F_PASS, 31'd0, 32'd64, 32'd40);
    store(32'h1000, 4'hF, 32'h1);
    check_out();

    // Reset from PASS, then rerun to FAIL.
    push_exp("reset_from_pass", F_NONE, 31'd0, 32'd0, 32'd0);
    do_reset();
    check_out();
    check_val("reset_from_pass.state", 32'(dbg_state), 32'(IDLE));
    arm();
    push_exp("rerun_fail", F_FAIL, 31'h4000_0001, 32'd1, 32'd0);
    store(32'h1000, 4'hF, 32'h8000_0003);
    check_out();

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
